ram_arb: RTL
============

RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 ADDR_W, 13, RAM address width; requester addresses at or above 2**ADDR_W are out of range.
REQ-002 DATA_W, 8, RAM data width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 booting  in  1  high: only boot requester is served.
REQ-006 {boot,cpu,dbg}_req  in  1  access request; held high until matching gnt.
REQ-007 {boot,cpu}_we  in  1  1 = write, 0 = read; dbg is read-only.
REQ-008 {boot,cpu,dbg}_addr  in  16  byte address.
REQ-009 {boot,cpu}_wdata  in  DATA_W  write data.
REQ-010 {boot,cpu,dbg}_gnt  out  1  one-cycle pulse: request accepted this cycle.
REQ-011 rdata  out  DATA_W  shared read data, qualified by rvalid.
REQ-012 rvalid  out  3  one-hot {dbg,cpu,boot}: rdata belongs to that requester.
REQ-013 err  out  1  one-cycle pulse: granted access was out of range.
REQ-014 ram_addr  out  ADDR_W  RAM address.
REQ-015 ram_we  out  1  RAM write strobe.
REQ-016 ram_wdata  out  DATA_W  RAM write data.
REQ-017 ram_rdata  in  DATA_W  RAM read data, valid one cycle after the address is presented.

Function
REQ-018 FSM states: IDLE, ACCESS, RDWAIT.
REQ-019 IDLE: if any eligible req is high, select the winner, latch its we/addr/wdata and index, then go to ACCESS; otherwise stay in IDLE.
REQ-020 Eligibility: booting=1 -> only boot; booting=0 -> boot, cpu and dbg are all eligible.
REQ-021 Priority: boot beats cpu and dbg; cpu vs dbg is resolved per REQ-036/037.
REQ-022 ACCESS: pulse the winner's gnt; drive ram_addr = latched addr[ADDR_W-1:0]; drive ram_we = latched we AND in-range; drive ram_wdata.
REQ-023 ACCESS next state: a write or out-of-range access -> IDLE; an in-range read -> RDWAIT.
REQ-024 RDWAIT: rdata = ram_rdata; pulse rvalid[winner]; go to IDLE.
REQ-025 Latency: request to gnt is 2 cycles; gnt to rvalid is 1 cycle; peak rate is one write every 2 cycles or one read every 3 cycles.
REQ-026 Out of range (addr[15:ADDR_W] != 0): ram_we=0, err pulses with gnt; a read additionally pulses rvalid with rdata=0 in the same cycle.
REQ-027 Requests and booting are sampled only in IDLE; changes during ACCESS or RDWAIT do not affect the access in flight.
REQ-028 A req dropped before its gnt is treated as withdrawn; no gnt is issued for it.
REQ-029 Simultaneous requests: exactly one gnt per access; losers keep waiting without any side effect.
REQ-030 A booting rising edge during an in-flight cpu/dbg access lets that access complete; the next IDLE then serves boot only.

Reset
REQ-031 rst asserts immediately and asynchronously; state -> IDLE.
REQ-032 Reset values: all gnt=0, rvalid=0, err=0, rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, round-robin pointer favours cpu.
REQ-033 An access in flight when rst asserts is abandoned; no gnt or rvalid is issued for it after reset releases.
REQ-034 ram_we is low throughout reset.

Configuration
REQ-035 Macro RAM_ARB_RR_EN selects the cpu/dbg arbitration policy.
REQ-036 RAM_ARB_RR_EN defined: cpu and dbg round-robin; the pointer toggles to the other requester after each cpu or dbg grant, and a boot grant does not change the pointer.
REQ-037 RAM_ARB_RR_EN undefined: fixed priority cpu > dbg; no pointer flop exists.

Structure
REQ-038 Package ram_arb_pkg holds: state enum (IDLE/ACCESS/RDWAIT), requester index constants (BOOT=0, CPU=1, DBG=2), default ADDR_W/DATA_W.
REQ-039 One sub-module, ram_arb_pick: combinational winner select plus the round-robin pointer flop, instantiated once.

Verification
REQ-040 booting=1, boot writes 0xA5 to 0x0010 -> boot_gnt 2 cycles after req, ram_we=1 and ram_addr=0x010 in that same cycle; a later cpu read of 0x0010 returns rdata=0xA5 with rvalid=3'b010.
REQ-041 booting=1 with cpu_req and dbg_req held high -> no cpu/dbg gnt while booting; after booting falls, both are served in turn.
REQ-042 RAM_ARB_RR_EN defined, cpu and dbg reading continuously -> gnts alternate cpu, dbg, cpu, dbg; with the macro undefined, only cpu is granted.
REQ-043 cpu write to 0x2000 (ADDR_W=13) -> cpu_gnt and err pulse together, ram_we stays 0; a dbg read of 0xFFFF gives rvalid[2]=1 with rdata=0 and err=1.
REQ-044 rst asserted in RDWAIT -> all outputs zero in the same cycle; after release, no stale rvalid appears and the FSM is in IDLE.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the three-requester RAM arbiter.
// Requester indices double as bit positions in the gnt/rvalid vectors.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] CPU  = 2'd1;
  localparam logic [1:0] DBG  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
    return 3'(3'b001 << idx);
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select for ram_arb: boot first, then cpu/dbg (round-robin when RAM_ARB_RR_EN).
// Latency: combinational select; the pointer advances on the edge that accepts a winner.
// Backpressure: none here; the caller only asserts take while idle.
module ram_arb_pick
  import ram_arb_pkg::*;
(
`ifdef RAM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       take,
`endif
  input  logic       booting,
  input  logic       boot_req,
  input  logic       cpu_req,
  input  logic       dbg_req,
  output logic       any_vld,
  output logic [1:0] win_idx
);

  logic cpu_elig;
  logic dbg_elig;

  assign cpu_elig = cpu_req & ~booting;
  assign dbg_elig = dbg_req & ~booting;
  assign any_vld  = boot_req | cpu_elig | dbg_elig;

`ifdef RAM_ARB_RR_EN
  // 1 = dbg wins the next cpu/dbg tie; boot grants leave it untouched
  logic ptr_dbg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_dbg <= 1'b0;
    end else if (take && (win_idx != BOOT)) begin
      ptr_dbg <= (win_idx == CPU);
    end
  end
`endif

  always_comb begin
    win_idx = BOOT;
    if (boot_req) begin
      win_idx = BOOT;
    end else if (cpu_elig && dbg_elig) begin
`ifdef RAM_ARB_RR_EN
      win_idx = ptr_dbg ? DBG : CPU;
`else
      win_idx = CPU;
`endif
    end else if (cpu_elig) begin
      win_idx = CPU;
    end else if (dbg_elig) begin
      win_idx = DBG;
    end
  end

endmodule

// File: rtl/ram_arb.sv
// Arbitrates boot/cpu/dbg onto one synchronous RAM; RAM_ARB_RR_EN makes cpu/dbg round-robin.
// Latency: req->gnt 2 cycles, gnt->rvalid 1 cycle; one write per 2 cycles, one read per 3.
// Backpressure: requesters hold req until gnt; losers and late arrivals simply wait.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              booting,
  input  logic              boot_req,
  input  logic              boot_we,
  input  logic [15:0]       boot_addr,
  input  logic [DATA_W-1:0] boot_wdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dbg_req,
  input  logic [15:0]       dbg_addr,
  output logic              boot_gnt,
  output logic              cpu_gnt,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        rvalid,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        lat_idx;
  logic              lat_we;
  logic [15:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              any_vld;
  logic [1:0]        win_idx;
  logic              take;
  logic              in_range;
  logic              sel_we;
  logic [15:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        gnt_vec;

  assign take     = (state == IDLE) & any_vld;
  assign in_range = ((lat_addr >> ADDR_W) == 16'd0);

  ram_arb_pick u_pick (
`ifdef RAM_ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
    .take     (take),
`endif
    .booting  (booting),
    .boot_req (boot_req),
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .any_vld  (any_vld),
    .win_idx  (win_idx)
  );

  // dbg is read-only, so its write fields are forced to zero
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = dbg_addr;
    sel_wdata = '0;
    case (win_idx)
      BOOT: begin
        sel_we    = boot_we;
        sel_addr  = boot_addr;
        sel_wdata = boot_wdata;
      end
      CPU: begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_idx   <= BOOT;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        lat_idx   <= win_idx;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end
    end
  end

  // Outputs decode purely from state so reset zeroes them immediately
  always_comb begin
    state_nxt = state;
    gnt_vec   = 3'b000;
    rvalid    = 3'b000;
    rdata     = '0;
    err       = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        if (any_vld) state_nxt = ACCESS;
      end
      ACCESS: begin
        gnt_vec   = idx_onehot(lat_idx);
        ram_addr  = lat_addr[ADDR_W-1:0];
        ram_wdata = lat_wdata;
        ram_we    = lat_we & in_range;
        if (!in_range) begin
          err       = 1'b1;
          if (!lat_we) rvalid = idx_onehot(lat_idx);
          state_nxt = IDLE;
        end else begin
          state_nxt = lat_we ? IDLE : RDWAIT;
        end
      end
      RDWAIT: begin
        rvalid    = idx_onehot(lat_idx);
        rdata     = ram_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign boot_gnt = gnt_vec[BOOT];
  assign cpu_gnt  = gnt_vec[CPU];
  assign dbg_gnt  = gnt_vec[DBG];

endmodule
